// File: rtl/deskew_ctrl_if.sv
// deskew_ctrl_if: lane status in, window/read/flush/status out between the deskew
// sequencer (master) and the lane FIFOs (slave).
interface deskew_ctrl_if #(parameter int NUM_LANES = 4);
    logic                 sym_lock;
    logic [NUM_LANES-1:0] fifo_not_empty;
    logic [2:0]           window_cnt;
    logic                 r_en;
    logic                 lane_flush;
    logic                 deskew_done;
    logic                 deskew_err;
    logic [7:0]           err_cnt;
    modport master (
        input  sym_lock, fifo_not_empty,
        output window_cnt, r_en, lane_flush, deskew_done, deskew_err, err_cnt
    );
    modport slave (
        output sym_lock, fifo_not_empty,
        input  window_cnt, r_en, lane_flush, deskew_done, deskew_err, err_cnt
    );
endinterface

// File: rtl/deskew_ctrl.sv
// deskew_ctrl: sequences lane deskew FIFOs through flush, write window, alignment and run.
// Define DESKEW_ERR_CNT_EN to build the saturating skew-violation counter; otherwise err_cnt is 0.
module deskew_ctrl #(
    parameter int NUM_LANES = 4,
    parameter int MAX_SKEW  = 3
) (
    input logic           clk_r_local,
    input logic           rst,
    deskew_ctrl_if.master bus
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] WINDOW = 3'd1;
    localparam logic [2:0] ALIGN  = 3'd2;
    localparam logic [2:0] RUN    = 3'd3;
    localparam logic [2:0] ERROR  = 3'd4;
    localparam logic [2:0] SKEW_MAX = 3'(MAX_SKEW);
    logic [2:0]           state, skew, window_cnt;
    logic [NUM_LANES-1:0] fne;
    logic                 err_phase, done, err_pulse;
    logic                 all_full, all_empty, active, partial, skew_err, err_set;
    assign fne       = bus.fifo_not_empty;
    assign all_full  = &fne;
    assign all_empty = ~|fne;
    assign active    = state == ALIGN || state == RUN;
    assign partial   = !all_full && !all_empty;
    assign skew_err  = active && partial && skew >= SKEW_MAX;
    // loss of lock outranks a skew violation in the same cycle
    assign err_set   = skew_err && bus.sym_lock;
    assign bus.r_en        = active && all_full;
    assign bus.lane_flush  = state == IDLE || state == ERROR;
    assign bus.window_cnt  = window_cnt;
    assign bus.deskew_done = done;
    assign bus.deskew_err  = err_pulse;
    always_ff @(posedge clk_r_local) begin
        if (rst) begin
            state      <= IDLE;
            window_cnt <= 3'd0;
            skew       <= 3'd0;
            done       <= 1'b0;
            err_pulse  <= 1'b0;
            err_phase  <= 1'b0;
        end else begin
            err_pulse <= 1'b0;
            err_phase <= 1'b0;
            skew      <= active && partial ? skew + 3'd1 : 3'd0;
            if (!bus.sym_lock && state != IDLE) begin
                state      <= IDLE;
                window_cnt <= 3'd0;
                done       <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        window_cnt <= 3'd0;
                        done       <= 1'b0;
                        if (bus.sym_lock) state <= WINDOW;
                    end
                    WINDOW: begin
                        window_cnt <= window_cnt + 3'd1;
                        if (window_cnt == 3'd3) state <= ALIGN;
                    end
                    ALIGN, RUN: begin
                        if (err_set) begin
                            state      <= ERROR;
                            err_pulse  <= 1'b1;
                            window_cnt <= 3'd0;
                            done       <= 1'b0;
                        end else if (bus.r_en) begin
                            state <= RUN;
                            done  <= 1'b1;
                        end
                    end
                    ERROR: begin
                        err_phase <= 1'b1;
                        if (err_phase) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
`ifdef DESKEW_ERR_CNT_EN
    logic [7:0] err_cnt;
    always_ff @(posedge clk_r_local) begin
        if (rst) err_cnt <= 8'd0;
        else if (err_set && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
    assign bus.err_cnt = err_cnt;
`else
    assign bus.err_cnt = 8'd0;
`endif
endmodule

// File: doc/deskew_ctrl.md
DESKEW_CTRL -- requirements
Module: deskew_ctrl

Interface
REQ-001 SHALL have parameter NUM_LANES, default 4, number of lanes whose deskew FIFOs are sequenced.
REQ-002 SHALL have parameter MAX_SKEW, default 3, maximum tolerated lane-to-lane skew in symbol cycles (1..7).
REQ-003 SHALL have port clk_r_local  input  1  local symbol clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port sym_lock  input  1  all lanes symbol-locked; 0 forces restart.
REQ-006 SHALL have port fifo_not_empty  input  NUM_LANES  per-lane deskew FIFO not-empty flags.
REQ-007 SHALL have port window_cnt  output  3  "count 4" counter broadcast to every lane FIFO; bit 2 enables deskew writes.
REQ-008 SHALL have port r_en  output  1  common read enable to all lane FIFOs.
REQ-009 SHALL have port lane_flush  output  1  held high to empty all lane FIFOs (drives their reset).
REQ-010 SHALL have port deskew_done  output  1  lanes aligned, data valid downstream.
REQ-011 SHALL have port deskew_err  output  1  one-cycle pulse on skew violation.
REQ-012 SHALL have port err_cnt  output  8  count of skew violations.

Function
REQ-013 SHALL implement states IDLE, WINDOW, ALIGN, RUN, ERROR as a registered FSM.
REQ-014 IDLE: lane_flush=1, window_cnt=0; go to WINDOW on cycle after sym_lock=1 sampled.
REQ-015 WINDOW: lane_flush=0; window_cnt increments by 1 per cycle 0->4; on the cycle window_cnt becomes 4 go to ALIGN.
REQ-016 window_cnt SHALL hold 4 in ALIGN and RUN, never exceed 4, and return to 0 in IDLE/ERROR.
REQ-017 r_en SHALL be combinational: 1 exactly when state is ALIGN or RUN and all fifo_not_empty bits are 1.
REQ-018 ALIGN->RUN on the first cycle r_en=1; deskew_done SHALL be registered, 1 in RUN only (rises one cycle after first r_en).
REQ-019 Skew counter (3 bits) SHALL increment each ALIGN/RUN cycle where fifo_not_empty is neither all-0 nor all-1, and clear otherwise and in other states.
REQ-020 When skew counter would exceed MAX_SKEW, SHALL go to ERROR next cycle and pulse deskew_err for exactly one cycle.
REQ-021 In RUN, all-0 fifo_not_empty (simultaneous SKP removal) SHALL NOT be an error; r_en=0 that cycle.
REQ-022 ERROR: lane_flush=1 for exactly 2 cycles, then IDLE.
REQ-023 sym_lock=0 in any state except IDLE SHALL go to IDLE next cycle with no deskew_err; takes priority over skew error in the same cycle.
REQ-024 err_cnt SHALL increment on each deskew_err pulse, saturating at 255.

Reset
REQ-025 rst=1 SHALL force state IDLE, window_cnt=0, skew counter=0, deskew_done=0, deskew_err=0, err_cnt=0, lane_flush=1, r_en=0, on the next rising edge, including mid-RUN.
REQ-026 rst SHALL have priority over all other inputs.

Configuration
REQ-027 Macro DESKEW_ERR_CNT_EN defined: err_cnt counter per REQ-024 is compiled in.
REQ-028 Macro DESKEW_ERR_CNT_EN undefined: no counter register; err_cnt tied to 0; all other behaviour identical.

Verification
REQ-029 Reset, sym_lock=1, all lanes fill on same cycle -> window_cnt 0,1,2,3,4 over 5 cycles after WINDOW entry; r_en=1 on first all-not-empty cycle; deskew_done=1 next cycle.
REQ-030 MAX_SKEW=3, lane0 not-empty 3 cycles before lanes1-3 -> no error, r_en rises when lane3 fills, RUN reached.
REQ-031 MAX_SKEW=3, lane0 alone not-empty 4 cycles -> deskew_err single pulse, lane_flush high 2 cycles, back to IDLE, err_cnt=1.
REQ-032 In RUN all lanes drop not-empty for 1 cycle -> r_en=0 that cycle, no deskew_err, stays RUN.
REQ-033 sym_lock falls in RUN -> IDLE next cycle, deskew_done=0, lane_flush=1, window_cnt=0, err_cnt unchanged.
REQ-034 300 forced violations with DESKEW_ERR_CNT_EN -> err_cnt=255; without macro -> err_cnt=0 throughout.
